// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream, writes little-endian 32-bit words into
// instruction memory from address 0, verifies a mod-256 checksum and then releases core reset.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]        state_q,    state_d;
  logic [15:0]       len_q,      len_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [1:0]        idx_q,      idx_d;
  logic [7:0]        sum_q,      sum_d;
  logic [31:0]       word_q,     word_d;
  logic              in_ready_q, in_ready_d;
  logic              im_we_q,    im_we_d;
  logic [ADDR_W-1:0] im_addr_q,  im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic              xfer;

  assign xfer = in_valid & in_ready_q;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      word_q     <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state so they
  // line up with the state they describe
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    word_d     = word_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          word_cnt_d = '0;
          idx_d      = '0;
          sum_d      = '0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d   = {len_q[15:8], in_data};
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d = {in_data, len_q[7:0]};
          if (len_d > 16'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else if (len_d == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{idx_q, 3'b000} +: 8] = in_data;
          sum_d = sum_q + in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d    = S_WRITE;
            im_we_d    = 1'b1;
            im_addr_d  = word_cnt_q[ADDR_W-1:0];
            im_wdata_d = word_d;
          end
        end
      end
      S_WRITE: begin
        idx_d = '0;
        if (16'(word_cnt_q) + 16'd1 == len_q) begin
          state_d = S_CSUM;
        end else begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          state_d    = S_DATA;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                 (state_d == S_DATA) || (state_d == S_CSUM);
    core_rst_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected memory writes are queued by the
// stimulus and popped by a monitor whenever im_we is seen.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;
  logic prev_we  = 1'b0;

  logic [7:0] good_f[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                            8'h93, 8'h05, 8'h40, 8'h01, 8'h91};
  logic [7:0] bad_f[$]  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                            8'h93, 8'h05, 8'h40, 8'h01, 8'h00};
  logic [7:0] big_f[$]  = '{8'h01, 8'h01};
  logic [7:0] part_f[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93};
  logic [7:0] zero_f[$] = '{8'h00, 8'h00, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_good();
    exp_q.push_back('{a: 8'd0, d: 32'h00A00513});
    exp_q.push_back('{a: 8'd1, d: 32'h01400593});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gap);
    foreach (f[i]) send_byte(f[i], gap);
  endtask

  task automatic wait_status(input string tag, input logic exp_done, input logic exp_err);
    int n;
    n = 0;
    while (!(done || err) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"},     32'(done),     32'(exp_done));
    check({tag, "_err"},      32'(err),      32'(exp_err));
    check({tag, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
    check({tag, "_pending"},  32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst === 1'b1 && im_we === 1'b1) begin
      check("we_back_to_back", 32'(prev_we), 32'd0);
      check("ready_in_write",  32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("im_addr",  32'(im_addr), 32'(e.a));
        check("im_wdata", im_wdata, e.d);
      end
    end
    prev_we = im_we;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_im_we",    32'(im_we),    32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Good load
    pulse_start();
    check("start_in_ready", 32'(in_ready), 32'd1);
    push_good();
    send_frame(good_f, 1'b0);
    wait_status("good", 1'b1, 1'b0);

    // Bad checksum, restarted from DONE
    pulse_start();
    check("restart_core_rst", 32'(core_rst), 32'd1);
    check("restart_done",     32'(done),     32'd0);
    push_good();
    send_frame(bad_f, 1'b0);
    wait_status("badsum", 1'b0, 1'b1);

    // Oversize length: error right after LEN_HI, no writes
    pulse_start();
    check("restart_err", 32'(err), 32'd0);
    send_frame(big_f, 1'b0);
    check("big_err",      32'(err),      32'd1);
    check("big_in_ready", 32'(in_ready), 32'd0);
    check("big_core_rst", 32'(core_rst), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("big_err_hold", 32'(err), 32'd1);

    // Gapped stream
    pulse_start();
    push_good();
    send_frame(good_f, 1'b1);
    wait_status("gaps", 1'b1, 1'b0);

    // Mid-load reset after 5 data bytes; first word is already written
    pulse_start();
    exp_q.push_back('{a: 8'd0, d: 32'h00A00513});
    send_frame(part_f, 1'b0);
    check("mid_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_core_rst", 32'(core_rst), 32'd1);
    check("mid_in_ready", 32'(in_ready), 32'd0);
    check("mid_im_we",    32'(im_we),    32'd0);
    check("mid_pending",  32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_idle_in_ready", 32'(in_ready), 32'd0);
    pulse_start();
    push_good();
    send_frame(good_f, 1'b0);
    wait_status("reload", 1'b1, 1'b0);

    // Zero-length image: checksum must be 00
    pulse_start();
    send_frame(zero_f, 1'b0);
    wait_status("zero_len", 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
